cnt_reg_demux: RTL and testbench



---
 rtl/cnt_reg_demux_pkg.sv | 44 ++++
 rtl/cnt_reg_addr_decode.sv | 36 +++
 rtl/cnt_reg_demux.sv | 151 +++++++++++++++
 tb/tb_cnt_reg_demux.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_reg_demux_pkg.sv
// Shared types for the register-interface demultiplexer: FSM state, address rule,
// default widths and typedef macros for building request/response structs.
`ifndef CNT_REG_DEMUX_PKG_SV
`define CNT_REG_DEMUX_PKG_SV

`define CNT_REG_TYPEDEF_REQ(name, aw, dw) \
    typedef struct packed { \
        logic              valid; \
        logic              write; \
        logic [(dw)/8-1:0] wstrb; \
        logic [(aw)-1:0]   addr; \
        logic [(dw)-1:0]   wdata; \
    } name;

`define CNT_REG_TYPEDEF_RSP(name, dw) \
    typedef struct packed { \
        logic            error; \
        logic            ready; \
        logic [(dw)-1:0] rdata; \
    } name;

package cnt_reg_demux_pkg;

    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_AW-1:0] base;
        logic [DEF_AW-1:0] mask;
    } addr_rule_t;

    `CNT_REG_TYPEDEF_REQ(reg_req_t, DEF_AW, DEF_DW)
    `CNT_REG_TYPEDEF_RSP(reg_rsp_t, DEF_DW)

endpackage

`endif

// File: rtl/cnt_reg_addr_decode.sv
// Combinational priority address decoder: the lowest-index rule whose masked
// address equals its base wins.
module cnt_reg_addr_decode
    import cnt_reg_demux_pkg::*;
#(
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned NTGT = 4,
    parameter int unsigned SW   = 2
) (
    input  logic [AW-1:0]            addr,
    input  logic [NTGT-1:0][AW-1:0]  base,
    input  logic [NTGT-1:0][AW-1:0]  mask,
    output logic [SW-1:0]            sel,
    output logic                     hit
);

    logic [NTGT-1:0] match_s;

    // Rule match vector.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < int'(NTGT); i++) begin
            match_s[i] = ((addr & mask[i]) == base[i]);
        end
    end

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        sel = '0;
        for (int i = int'(NTGT) - 1; i >= 0; i--) begin
            sel = match_s[i] ? SW'(i) : sel;
        end
        hit = |match_s;
    end

endmodule

// File: rtl/cnt_reg_demux.sv
// Register-interface demultiplexer: registers one upstream request, forwards it to
// the decoded target, and answers misses/timeouts with an error plus a counter.
module cnt_reg_demux
    import cnt_reg_demux_pkg::*;
#(
    parameter int unsigned               AW      = DEF_AW,
    parameter int unsigned               DW      = DEF_DW,
    parameter int unsigned               NTGT    = 4,
    parameter int unsigned               TIMEOUT = DEF_TIMEOUT,
    parameter logic [NTGT-1:0][AW-1:0]   BASE    = '0,
    parameter logic [NTGT-1:0][AW-1:0]   MASK    = '0,
    parameter int unsigned               CW      = 16,
    parameter type                       req_t   = reg_req_t,
    parameter type                       rsp_t   = reg_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  req_t                   in_req_i,
    output rsp_t                   in_rsp_o,
    output req_t [NTGT-1:0]        out_req_o,
    input  rsp_t [NTGT-1:0]        out_rsp_i,
    input  logic                   clr_i,
    output logic                   timeout_o,
    output logic [CW-1:0]          err_cnt_o
);

    localparam int unsigned SW = (NTGT > 32'd1) ? $clog2(NTGT) : 32'd1;
    // The wait counter only has to reach TIMEOUT-1.
    localparam int unsigned WW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 32'd0) ? TIMEOUT - 32'd1 : 32'd0);

    state_e          state_r;
    req_t            req_r;
    logic [SW-1:0]   sel_r;
    logic [DW-1:0]   rdata_r;
    logic            error_r;
    logic [WW-1:0]   wait_r;
    logic            timeout_r;
    logic [CW-1:0]   err_cnt_r;

    logic [SW-1:0]   dec_sel_s;
    logic            dec_hit_s;
    logic            tgt_ready_s;
    logic            miss_s;
    logic            expire_s;

    cnt_reg_addr_decode #(
        .AW   (AW),
        .NTGT (NTGT),
        .SW   (SW)
    ) u_decode (
        .addr (in_req_i.addr),
        .base (BASE),
        .mask (MASK),
        .sel  (dec_sel_s),
        .hit  (dec_hit_s)
    );

    // Error events; a target ready on the last allowed cycle beats the timeout.
    always_comb begin
        tgt_ready_s = out_rsp_i[sel_r].ready;
        miss_s      = (state_r == IDLE) && in_req_i.valid && !dec_hit_s;
        expire_s    = (state_r == ISSUE) && !tgt_ready_s &&
                      (TIMEOUT != 32'd0) && (wait_r == WAIT_LAST);
    end

    // Transaction FSM with request/response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            req_r     <= '0;
            sel_r     <= '0;
            rdata_r   <= '0;
            error_r   <= 1'b0;
            wait_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_req_i.valid) begin
                        req_r  <= in_req_i;
                        sel_r  <= dec_sel_s;
                        wait_r <= '0;
                        if (dec_hit_s) begin
                            state_r <= ISSUE;
                        end else begin
                            rdata_r <= '0;
                            error_r <= 1'b1;
                            state_r <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (tgt_ready_s) begin
                        rdata_r <= req_r.write ? '0 : out_rsp_i[sel_r].rdata;
                        error_r <= out_rsp_i[sel_r].error;
                        state_r <= RESP;
                    end else if (expire_s) begin
                        rdata_r   <= '0;
                        error_r   <= 1'b1;
                        timeout_r <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        wait_r <= wait_r + WW'(1'b1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Saturating miss/timeout counter; clear beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_r <= '0;
        end else if (clr_i) begin
            err_cnt_r <= '0;
        end else if ((miss_s || expire_s) && (err_cnt_r != {CW{1'b1}})) begin
            err_cnt_r <= err_cnt_r + CW'(1'b1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        in_rsp_o       = '0;
        in_rsp_o.ready = (state_r == RESP);
        in_rsp_o.rdata = rdata_r;
        in_rsp_o.error = error_r;
        for (int j = 0; j < int'(NTGT); j++) begin
            if ((state_r == ISSUE) && (sel_r == SW'(j))) begin
                out_req_o[j]       = req_r;
                out_req_o[j].valid = 1'b1;
            end else begin
                out_req_o[j] = '0;
            end
        end
        timeout_o = timeout_r;
        err_cnt_o = err_cnt_r;
    end

endmodule

// File: tb/tb_cnt_reg_demux.sv
// Randomised self-checking bench for cnt_reg_demux against a transaction-level model
// (four 4 KiB windows at 0x0000..0x3FFF, TIMEOUT=4, 2-bit error counter).
module tb_cnt_reg_demux;
    import cnt_reg_demux_pkg::*;

    localparam int NT  = 4;
    localparam int TO  = 4;
    localparam int CWD = 2;
    localparam int CNT_MAX = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    reg_req_t             in_req;
    reg_rsp_t             in_rsp;
    reg_req_t [NT-1:0]    out_req;
    reg_rsp_t [NT-1:0]    out_rsp;
    logic                 clr;
    logic                 tmo;
    logic [CWD-1:0]       ecnt;

    int total = 0;
    int bad   = 0;
    int mcnt  = 0;

    always #5 clk = ~clk;

    cnt_reg_demux #(
        .AW      (32),
        .DW      (32),
        .NTGT    (NT),
        .TIMEOUT (TO),
        .BASE    ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .MASK    ({4{32'hFFFF_F000}}),
        .CW      (CWD),
        .req_t   (reg_req_t),
        .rsp_t   (reg_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_req_i  (in_req),
        .in_rsp_o  (in_rsp),
        .out_req_o (out_req),
        .out_rsp_i (out_rsp),
        .clr_i     (clr),
        .timeout_o (tmo),
        .err_cnt_o (ecnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_valids(input string tag, input int sel);
        for (int j = 0; j < NT; j++) begin
            chk(tag, {127'd0, out_req[j].valid}, {127'd0, (j == sel)});
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    // One full upstream transaction; k = ISSUE cycle in which the target answers.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int k, input logic [31:0] rd,
                           input logic re, input logic c, input logic scramble);
        bit hit;
        int sel;
        bit done;
        hit = (addr < 32'h0000_4000);
        sel = hit ? int'(addr >> 12) : -1;
        @(negedge clk);
        in_req  = '{valid: 1'b1, write: wr, wstrb: strb, addr: addr, wdata: wdata};
        clr     = c;
        out_rsp = '0;
        @(posedge clk); #1;
        clr = 1'b0;
        if (c) mcnt = 0;
        if (!hit) begin
            if (!c) mcnt = sat_inc(mcnt);
            chk("miss_ready", {127'd0, in_rsp.ready}, 128'd1);
            chk("miss_error", {127'd0, in_rsp.error}, 128'd1);
            chk("miss_rdata", {96'd0, in_rsp.rdata}, 128'd0);
            chk("miss_tmo", {127'd0, tmo}, 128'd0);
            chk_valids("miss_valid", -1);
            chk("miss_cnt", {126'd0, ecnt}, 128'(mcnt));
        end else begin
            done = 1'b0;
            for (int cy = 0; cy < TO && !done; cy++) begin
                chk_valids("issue_valid", sel);
                chk("issue_addr", {96'd0, out_req[sel].addr}, {96'd0, addr});
                chk("issue_write", {127'd0, out_req[sel].write}, {127'd0, wr});
                chk("issue_wdata", {96'd0, out_req[sel].wdata}, {96'd0, wdata});
                chk("issue_wstrb", {124'd0, out_req[sel].wstrb}, {124'd0, strb});
                chk("issue_noready", {127'd0, in_rsp.ready}, 128'd0);
                chk("issue_tmo", {127'd0, tmo}, 128'd0);
                if (scramble) begin
                    in_req.addr  = $urandom;
                    in_req.wdata = $urandom;
                    in_req.write = ~wr;
                end
                if (cy == k) begin
                    out_rsp[sel].ready = 1'b1;
                    out_rsp[sel].rdata = rd;
                    out_rsp[sel].error = re;
                    done = 1'b1;
                end
                @(posedge clk); #1;
                out_rsp = '0;
            end
            if (!done) mcnt = sat_inc(mcnt);
            chk("resp_ready", {127'd0, in_rsp.ready}, 128'd1);
            chk("resp_rdata", {96'd0, in_rsp.rdata}, {96'd0, (done && !wr) ? rd : 32'd0});
            chk("resp_error", {127'd0, in_rsp.error}, {127'd0, done ? re : 1'b1});
            chk("resp_tmo", {127'd0, tmo}, {127'd0, !done});
            chk_valids("resp_valid", -1);
            chk("resp_cnt", {126'd0, ecnt}, 128'(mcnt));
        end
        // Upstream valid is still high across the RESP edge; it must not start a new transaction.
        @(posedge clk); #1;
        in_req = '0;
        chk("idle_ready", {127'd0, in_rsp.ready}, 128'd0);
        chk("idle_tmo", {127'd0, tmo}, 128'd0);
        chk_valids("idle_valid", -1);
        @(posedge clk); #1;
        chk("idle2_ready", {127'd0, in_rsp.ready}, 128'd0);
        chk_valids("idle2_valid", -1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rsp"}, {94'd0, in_rsp}, 128'd0);
        for (int j = 0; j < NT; j++) begin
            chk({tag, "_req"}, {58'd0, out_req[j]}, 128'd0);
        end
        chk({tag, "_tmo"}, {127'd0, tmo}, 128'd0);
        chk({tag, "_cnt"}, {126'd0, ecnt}, 128'd0);
    endtask

    initial begin
        logic [31:0] a;
        in_req  = '0;
        out_rsp = '0;
        clr     = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Directed cases.
        run_txn(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        run_txn(32'h8000_0000, 1'b1, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_txn(32'h0000_2008, 1'b0, 32'h0, 4'h0, 99, 32'h0, 1'b0, 1'b0, 1'b0);
        run_txn(32'h0000_3010, 1'b0, 32'h0, 4'h0, TO - 1, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b1);
        run_txn(32'h0000_0ffc, 1'b1, 32'hDEAD_BEEF, 4'h3, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_txn(32'h0001_0000 + 32'(i), 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        run_txn(32'hFFFF_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Reset while a transaction is waiting on its target.
        @(negedge clk);
        in_req = '{valid: 1'b1, write: 1'b0, wstrb: 4'h0, addr: 32'h0000_3010, wdata: 32'h0};
        @(posedge clk); #1;
        chk_valids("rst_mid_pre", 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        mcnt = 0;
        chk_reset_state("rst_mid");
        in_req = '0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_idle", {127'd0, in_rsp.ready}, 128'd0);
        run_txn(32'h0000_2040, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 32'h3FFF));
            else                           a = $urandom | 32'h0000_4000;
            run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
